nf_wb_bridge: RTL and testbench



---
 rtl/nf_pkg.sv | 36 +++
 rtl/nf_wait_cnt.sv | 34 +++
 rtl/nf_wb_bridge.sv | 211 +++++++++++++++++++++
 tb/tb_nf_wb_bridge.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nf_pkg.sv
// Shared definitions for the Wishbone-to-NOR-flash bridge: FSM encoding,
// 50 MHz board timing defaults and flash bus geometry.
package nf_pkg;

  localparam int NF_AW = 21;
  localparam int NF_DW = 16;

  localparam int RD_WAIT_DEF    = 4;
  localparam int WR_SETUP_DEF   = 1;
  localparam int WR_PULSE_DEF   = 3;
  localparam int WR_HOLD_DEF    = 1;
  localparam int TURNAROUND_DEF = 1;
  localparam int RP_CYCLES_DEF  = 10;

  typedef enum logic [3:0] {
    ST_RP_PULSE,
    ST_IDLE,
    ST_RD_ACC,
    ST_RD_ACK,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_WR_ACK,
    ST_GAP
  } nf_state_e;

  // A timing value of zero still needs one cycle in its state.
  function automatic int nf_clamp1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int nf_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nf_wait_cnt.sv
// Loadable down-counter shared by every timed bridge state; done while zero.
module nf_wait_cnt #(
  parameter int            CW      = 4,
  parameter logic [CW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/nf_wb_bridge.sv
// Wishbone slave driving a 16-bit word-mode NOR flash with timed read and
// program/command write cycles, plus the power-on NF_RP pulse.
module nf_wb_bridge
  import nf_pkg::*;
#(
  parameter int RD_WAIT    = RD_WAIT_DEF,
  parameter int WR_SETUP   = WR_SETUP_DEF,
  parameter int WR_PULSE   = WR_PULSE_DEF,
  parameter int WR_HOLD    = WR_HOLD_DEF,
  parameter int TURNAROUND = TURNAROUND_DEF,
  parameter int RP_CYCLES  = RP_CYCLES_DEF,
  parameter int WRITE_EN   = 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic [NF_AW-1:0] wb_adr_i,
  input  logic [NF_DW-1:0] wb_dat_i,
  output logic [NF_DW-1:0] wb_dat_o,
  input  logic [1:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  output logic             wb_ack_o,
  inout  wire  [NF_DW-1:0] NF_D,
  output logic [NF_AW-1:0] NF_A,
  output logic             NF_WE,
  output logic             NF_CE,
  output logic             NF_OE,
  output logic             NF_BYTE,
  output logic             NF_RP
);

  localparam int RD_T  = nf_clamp1(RD_WAIT);
  localparam int SU_T  = nf_clamp1(WR_SETUP);
  localparam int PW_T  = nf_clamp1(WR_PULSE);
  localparam int HD_T  = nf_clamp1(WR_HOLD);
  localparam int TA_T  = nf_clamp1(TURNAROUND);
  localparam int RP_T  = nf_clamp1(RP_CYCLES);
  localparam int MAX_T = nf_max(nf_max(nf_max(RD_T, SU_T), nf_max(PW_T, HD_T)),
                                nf_max(TA_T, RP_T));
  localparam int CW    = $clog2(MAX_T + 1);

  localparam logic [CW-1:0] RD_LD = CW'(RD_T - 1);
  localparam logic [CW-1:0] SU_LD = CW'(SU_T - 1);
  localparam logic [CW-1:0] PW_LD = CW'(PW_T - 1);
  localparam logic [CW-1:0] HD_LD = CW'(HD_T - 1);
  localparam logic [CW-1:0] TA_LD = CW'(TA_T - 1);
  localparam logic [CW-1:0] RP_LD = CW'(RP_T - 1);

  nf_state_e        state_q, state_d;
  logic [NF_AW-1:0] adr_q, adr_d;
  logic [NF_DW-1:0] wdat_q, wdat_d;
  logic             abort_q, abort_d;
  logic [NF_AW-1:0] nf_a_q, nf_a_d;
  logic             nf_ce_q, nf_ce_d;
  logic             nf_oe_q, nf_oe_d;
  logic             nf_we_q, nf_we_d;
  logic             nf_rp_q, nf_rp_d;
  logic             nf_d_oe_q, nf_d_oe_d;
  logic [NF_DW-1:0] nf_d_out_q, nf_d_out_d;
  logic             ack_q, ack_d;
  logic [NF_DW-1:0] dat_q, dat_d;

  logic             req;
  logic             cnt_load;
  logic [CW-1:0]    cnt_val;
  logic             cnt_done;
  logic             rd_active;
  logic             wr_drive;

  assign req = wb_cyc_i & wb_stb_i;

  nf_wait_cnt #(
    .CW      (CW),
    .RST_VAL (RP_LD)
  ) u_wait (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_ni),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    wdat_d   = wdat_q;
    abort_d  = abort_q;
    cnt_load = 1'b0;
    cnt_val  = '0;

    // Once a flash cycle starts it always completes; a dropped cyc only kills the ack.
    if (state_q != ST_IDLE && state_q != ST_RP_PULSE && !wb_cyc_i) begin
      abort_d = 1'b1;
    end

    case (state_q)
      ST_RP_PULSE: begin
        if (cnt_done) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (req) begin
          adr_d   = wb_adr_i;
          wdat_d  = {wb_sel_i[1] ? wb_dat_i[15:8] : 8'h00,
                     wb_sel_i[0] ? wb_dat_i[7:0]  : 8'h00};
          abort_d = 1'b0;
          if (!wb_we_i) begin
            state_d  = ST_RD_ACC;
            cnt_load = 1'b1;
            cnt_val  = RD_LD;
          end else if (WRITE_EN == 0 || wb_sel_i == 2'b00) begin
            state_d = ST_WR_ACK;
          end else begin
            state_d  = ST_WR_SETUP;
            cnt_load = 1'b1;
            cnt_val  = SU_LD;
          end
        end
      end
      ST_RD_ACC: begin
        if (cnt_done) state_d = ST_RD_ACK;
      end
      ST_RD_ACK, ST_WR_ACK: begin
        state_d  = ST_GAP;
        cnt_load = 1'b1;
        cnt_val  = TA_LD;
      end
      ST_WR_SETUP: begin
        if (cnt_done) begin
          state_d  = ST_WR_PULSE;
          cnt_load = 1'b1;
          cnt_val  = PW_LD;
        end
      end
      ST_WR_PULSE: begin
        if (cnt_done) begin
          state_d  = ST_WR_HOLD;
          cnt_load = 1'b1;
          cnt_val  = HD_LD;
        end
      end
      ST_WR_HOLD: begin
        if (cnt_done) state_d = ST_WR_ACK;
      end
      ST_GAP: begin
        if (cnt_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pins follow the current state one edge later, so every pin is a plain flop.
  always_comb begin
    rd_active  = (state_q == ST_RD_ACC);
    wr_drive   = (state_q == ST_WR_SETUP) || (state_q == ST_WR_PULSE) ||
                 (state_q == ST_WR_HOLD);
    nf_a_d     = (rd_active || wr_drive) ? adr_q : nf_a_q;
    nf_ce_d    = !(rd_active || wr_drive);
    nf_oe_d    = !rd_active;
    nf_we_d    = (state_q != ST_WR_PULSE);
    nf_d_oe_d  = wr_drive;
    nf_d_out_d = wdat_q;
    ack_d      = ((state_q == ST_RD_ACK) || (state_q == ST_WR_ACK)) &&
                 !abort_q && wb_cyc_i;
    dat_d      = (state_q == ST_RD_ACK) ? NF_D : dat_q;
    nf_rp_d    = (state_d != ST_RP_PULSE);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= ST_RP_PULSE;
      abort_q   <= 1'b0;
      nf_a_q    <= '0;
      nf_ce_q   <= 1'b1;
      nf_oe_q   <= 1'b1;
      nf_we_q   <= 1'b1;
      nf_rp_q   <= 1'b0;
      nf_d_oe_q <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      abort_q   <= abort_d;
      nf_a_q    <= nf_a_d;
      nf_ce_q   <= nf_ce_d;
      nf_oe_q   <= nf_oe_d;
      nf_we_q   <= nf_we_d;
      nf_rp_q   <= nf_rp_d;
      nf_d_oe_q <= nf_d_oe_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    adr_q      <= adr_d;
    wdat_q     <= wdat_d;
    nf_d_out_q <= nf_d_out_d;
  end

  assign NF_D     = nf_d_oe_q ? nf_d_out_q : {NF_DW{1'bz}};
  assign NF_A     = nf_a_q;
  assign NF_CE    = nf_ce_q;
  assign NF_OE    = nf_oe_q;
  assign NF_WE    = nf_we_q;
  assign NF_RP    = nf_rp_q;
  assign NF_BYTE  = 1'b1;
  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_nf_wb_bridge.sv
// Directed bench for nf_wb_bridge with a word-addressed flash stub on NF_D.
module tb_nf_wb_bridge;

  logic        clk;
  logic        rst_n;
  logic [20:0] wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;
  wire  [15:0] NF_D;
  logic [20:0] NF_A;
  logic        NF_WE;
  logic        NF_CE;
  logic        NF_OE;
  logic        NF_BYTE;
  logic        NF_RP;
  logic [15:0] stub_dat;

  int checks = 0;
  int errors = 0;

  int cyc_idx, first_ack, first_oe, first_we, first_ce;
  int n_ack, n_oe, n_we, n_ce, n_dbad;
  logic [15:0] exp_d;
  bit drop_on_ack;

  nf_wb_bridge dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_sel_i  (wb_sel_i),
    .wb_we_i   (wb_we_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_ack_o  (wb_ack_o),
    .NF_D      (NF_D),
    .NF_A      (NF_A),
    .NF_WE     (NF_WE),
    .NF_CE     (NF_CE),
    .NF_OE     (NF_OE),
    .NF_BYTE   (NF_BYTE),
    .NF_RP     (NF_RP)
  );

  // Flash stub: one known word, every other address returns A ^ 16'h5A5A.
  assign stub_dat = (NF_A == 21'h000100) ? 16'hA55A : (NF_A[15:0] ^ 16'h5A5A);
  assign NF_D = (!NF_CE && !NF_OE) ? stub_dat : 16'bz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert (!(dut.nf_d_oe_q && (NF_OE === 1'b0))) else begin
        errors++;
        $error("FAIL bus_contention: drive=%0b oe=%0b required drive=0 while oe=0",
               dut.nf_d_oe_q, NF_OE);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cyc_idx   = 0;
    first_ack = -1;
    first_oe  = -1;
    first_we  = -1;
    first_ce  = -1;
    n_ack     = 0;
    n_oe      = 0;
    n_we      = 0;
    n_ce      = 0;
    n_dbad    = 0;
  endtask

  task automatic req(input logic w, input logic [20:0] a, input logic [15:0] d,
                     input logic [1:0] s);
    wb_we_i  = w;
    wb_adr_i = a;
    wb_dat_i = d;
    wb_sel_i = s;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc_idx++;
      if (wb_ack_o) begin n_ack++; if (first_ack < 0) first_ack = cyc_idx; end
      if (!NF_OE)   begin n_oe++;  if (first_oe  < 0) first_oe  = cyc_idx; end
      if (!NF_WE)   begin n_we++;  if (first_we  < 0) first_we  = cyc_idx; end
      if (!NF_CE)   begin n_ce++;  if (first_ce  < 0) first_ce  = cyc_idx; end
      if (!NF_CE && NF_OE && (NF_D !== exp_d)) n_dbad++;
      if (wb_ack_o && drop_on_ack) begin
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = 2'b11;
    wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    exp_d = '0; drop_on_ack = 1'b1;
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce",   32'(NF_CE),    32'd1);
    chk("rst_oe",   32'(NF_OE),    32'd1);
    chk("rst_we",   32'(NF_WE),    32'd1);
    chk("rst_rp",   32'(NF_RP),    32'd0);
    chk("rst_byte", 32'(NF_BYTE),  32'd1);
    chk("rst_a",    32'(NF_A),     32'd0);
    chk("rst_ack",  32'(wb_ack_o), 32'd0);
    chk("rst_dat",  32'(wb_dat_o), 32'd0);

    // Read issued before reset release: NF_RP low 10 cycles, request stalls.
    req(1'b0, 21'h000100, 16'h0000, 2'b11);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      chk("rp_pulse",  32'(NF_RP),    (i == 10) ? 32'd1 : 32'd0);
      chk("rp_noack",  32'(wb_ack_o), 32'd0);
    end
    clr();
    run(8);
    chk("rp_rd_ack_at", 32'(first_ack), 32'd6);
    chk("rp_rd_nack",   32'(n_ack),     32'd1);
    chk("rp_rd_dat",    32'(wb_dat_o),  32'h0000A55A);
    chk("rp_rd_a",      32'(NF_A),      32'h00000100);

    // Plain read from idle.
    clr();
    req(1'b0, 21'h000200, 16'h0000, 2'b00);
    run(10);
    chk("rd_oe_first", 32'(first_oe),  32'd2);
    chk("rd_oe_len",   32'(n_oe),      32'd4);
    chk("rd_ack_at",   32'(first_ack), 32'd6);
    chk("rd_nack",     32'(n_ack),     32'd1);
    chk("rd_dat",      32'(wb_dat_o),  32'h0000585A);
    chk("rd_we_idle",  32'(n_we),      32'd0);

    // Command write.
    clr();
    exp_d = 16'h0090;
    req(1'b1, 21'h000555, 16'h0090, 2'b11);
    run(10);
    chk("wr_ce_first", 32'(first_ce),  32'd2);
    chk("wr_ce_len",   32'(n_ce),      32'd5);
    chk("wr_we_first", 32'(first_we),  32'd3);
    chk("wr_we_len",   32'(n_we),      32'd3);
    chk("wr_oe_high",  32'(n_oe),      32'd0);
    chk("wr_data",     32'(n_dbad),    32'd0);
    chk("wr_ack_at",   32'(first_ack), 32'd7);
    chk("wr_nack",     32'(n_ack),     32'd1);
    chk("wr_a",        32'(NF_A),      32'h00000555);

    // Write with no byte lanes: ack next cycle, no flash activity.
    clr();
    req(1'b1, 21'h000123, 16'hFFFF, 2'b00);
    run(5);
    chk("sel0_ack_at", 32'(first_ack), 32'd2);
    chk("sel0_nack",   32'(n_ack),     32'd1);
    chk("sel0_ce",     32'(n_ce),      32'd0);
    chk("sel0_we",     32'(n_we),      32'd0);

    // Back-to-back: read, then a write presented without releasing the bus.
    clr();
    drop_on_ack = 1'b0;
    req(1'b0, 21'h000300, 16'h0000, 2'b11);
    run(6);
    chk("b2b_rd_ack_at", 32'(first_ack), 32'd6);
    chk("b2b_rd_dat",    32'(wb_dat_o),  32'h0000595A);
    clr();
    drop_on_ack = 1'b1;
    exp_d = 16'h0034;
    req(1'b1, 21'h000301, 16'h1234, 2'b01);
    run(10);
    chk("b2b_gap_ce",    32'(first_ce),  32'd3);
    chk("b2b_we_first",  32'(first_we),  32'd4);
    chk("b2b_we_len",    32'(n_we),      32'd3);
    chk("b2b_oe",        32'(n_oe),      32'd0);
    chk("b2b_data",      32'(n_dbad),    32'd0);
    chk("b2b_ack_at",    32'(first_ack), 32'd8);
    chk("b2b_a",         32'(NF_A),      32'h00000301);

    // Abort: cyc drops one cycle after NF_WE falls.
    clr();
    exp_d = 16'hBEEF;
    req(1'b1, 21'h000042, 16'hBEEF, 2'b11);
    run(4);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    run(6);
    chk("abort_we_len", 32'(n_we),   32'd3);
    chk("abort_ce_len", 32'(n_ce),   32'd5);
    chk("abort_noack",  32'(n_ack),  32'd0);
    chk("abort_data",   32'(n_dbad), 32'd0);

    // Back in idle after the abort.
    clr();
    req(1'b0, 21'h000100, 16'h0000, 2'b11);
    run(8);
    chk("post_abort_ack_at", 32'(first_ack), 32'd6);
    chk("post_abort_dat",    32'(wb_dat_o),  32'h0000A55A);

    // Asynchronous reset in the middle of the WE pulse.
    clr();
    exp_d = 16'h1111;
    req(1'b1, 21'h000007, 16'h1111, 2'b11);
    run(3);
    chk("arst_we_low", 32'(NF_WE), 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_we",    32'(NF_WE),          32'd1);
    chk("arst_ce",    32'(NF_CE),          32'd1);
    chk("arst_rp",    32'(NF_RP),          32'd0);
    chk("arst_d_rel", 32'(dut.nf_d_oe_q),  32'd0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("arst_rp_back", 32'(NF_RP), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
